jk_bank_driver: RTL and testbench
=================================

# jk_bank_driver

Command-driven stimulus generator for a bank of posedge JK flip-flops with active-low clear/preset; it is the producing end of the J/K/ClrN/PreN interface. It accepts a command and target value over a valid/ready handshake, derives per-bit J/K from the bank's current Q, and drives one excitation cycle. It then checks Q against the target and retries up to a limit. It sits between a test sequencer or controller and the flop bank, replacing hand-written J/K stimulus.

## Interface
- WIDTH, 4, number of JK flops in the bank
- MAX_RETRY, 2, extra drive attempts after a failed check (0..7)
- USE_TOGGLE, 0, 1: every changing bit uses J=K=1; 0: set/reset encoding
- CLK  in  1  rising-edge clock, shared with the flop bank
- Rst  in  1  synchronous, active-high reset
- CmdValid  in  1  command present
- CmdReady  out  1  driver can accept a command
- CmdOp  in  2  00 LOAD target, 01 CLEAR, 10 PRESET, 11 TOGGLE all
- CmdTgt  in  WIDTH  target value for LOAD; ignored otherwise
- Q  in  WIDTH  bank outputs (feedback)
- J, K  out  WIDTH each  excitation to bank
- ClrN, PreN  out  1 each  active-low bank clear / preset
- Done  out  1  one-cycle pulse: command finished
- Err  out  1  valid with Done: final check failed

## Operation
- One clock domain (CLK); synchronous, active-high reset (Rst).
- States: IDLE, DRIVE, CHECK, FIN.
- IDLE: CmdReady=1. On CmdValid&CmdReady, latch op and target, go to DRIVE, and clear the retry counter. LOAD/CLEAR/PRESET/TOGGLE set the expected value to CmdTgt / 0 / all-ones / ~Q sampled at accept.
- DRIVE: outputs are active for exactly one cycle, then go to CHECK.
  - LOAD with USE_TOGGLE=0: per bit, Q=0,T=1 gives J=1,K=0; Q=1,T=0 gives J=0,K=1; equal gives J=K=0.
  - LOAD with USE_TOGGLE=1: a differing bit gives J=K=1; an equal bit gives 0,0.
  - CLEAR: ClrN=0, J=K=0. PRESET: PreN=0, J=K=0.
  - TOGGLE: J=K=all-ones on the first attempt. On a retry, the LOAD encoding toward the expected value is used.
- CHECK: J=K=0, ClrN=PreN=1; compare Q with the expected value.
  - Match: go to FIN with Err=0.
  - Mismatch with retries<MAX_RETRY: increment the counter and return to DRIVE. The excitation is recomputed from the current Q.
  - Mismatch otherwise: go to FIN with Err=1.
- FIN: Done=1 for one cycle, Err valid; then return to IDLE.
- ClrN and PreN are never low simultaneously. The outputs are never J=K=1 in a CLEAR or PRESET cycle.
- Width rules: all bit operations are WIDTH-wide, and the retry counter is 3 bits.

## Timing
- Reset values: CmdReady=0 while Rst=1 and 1 in the first IDLE cycle after. J=K=0, ClrN=PreN=1, Done=Err=0. State=IDLE.
- Rst in any state: the next cycle is IDLE with reset outputs. The in-flight command is dropped and no Done is issued.
- Accept at edge n; DRIVE occupies cycle n+1. The bank updates on edge n+2, and CHECK samples Q in cycle n+2.
- Latency with no retry: Done in cycle n+3, and CmdReady again in n+4. Each retry adds 2 cycles.
- CmdReady=0 in DRIVE, CHECK and FIN. A CmdValid held during these states waits and is not lost.
- LOAD with target equal to Q still runs DRIVE (all zeros) and CHECK, giving Done with Err=0.

## Structure
- Shared package: op encodings (OP_LOAD, OP_CLEAR, OP_PRESET, OP_TOGGLE), state encodings, and a `jk_excite` function (Q, T, use_toggle) returning {J,K}.
- One natural sub-module: `jk_excite_bit`, a combinational per-bit excitation cell generated WIDTH times. The FSM, retry counter and latches stay in the top module.

## Test plan
- Reset: assert Rst for 2 cycles mid-DRIVE → the next cycle has J=K=0, ClrN=PreN=1, Done=0, and CmdReady=1 one cycle after Rst deasserts.
- LOAD 4'b1010 from Q=4'b0110, USE_TOGGLE=0 → the DRIVE cycle has J=4'b1000, K=4'b0100. Q=4'b1010 at CHECK; Done at n+3 with Err=0.
- Same LOAD with USE_TOGGLE=1 → J=K=4'b1100; Q=4'b1010 and Err=0.
- CLEAR then PRESET back-to-back with CmdValid held high → ClrN=0 for one cycle and Q=0000. PreN=0 for one cycle, 4 cycles later, and Q=1111; two Done pulses, and the strobes never overlap.
- Stuck bit (bench forces Q[0]=0), LOAD 4'b0001, MAX_RETRY=2 → three DRIVE cycles each with J[0]=1, then Done with Err=1 at n+7.
- TOGGLE from Q=4'b0011 → J=K=1111 for one cycle; Q=1100 and Err=0.

Source files
------------

// File: rtl/jk_bank_driver_pkg.sv
// Shared definitions for the JK bank driver: command/state encodings and
// the per-bit excitation rule used to move a JK flop from Q toward T.
package jk_bank_driver_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_PRESET = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  // Returns {J,K}; a bit already at its target is left alone (hold).
  function automatic logic [1:0] jk_excite(input logic q,
                                           input logic t,
                                           input logic use_toggle);
    logic [1:0] jk;
    if (q == t) begin
      jk = 2'b00;
    end else if (use_toggle) begin
      jk = 2'b11;
    end else if (t) begin
      jk = 2'b10;
    end else begin
      jk = 2'b01;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank_driver_excite_bit.sv
// Combinational excitation cell for one flop of the bank.
module jk_excite_bit
  import jk_bank_driver_pkg::*;
(
  input  logic q_i,
  input  logic t_i,
  input  logic use_toggle_i,
  output logic j_o,
  output logic k_o
);

  logic [1:0] jk;

  assign jk  = jk_excite(q_i, t_i, use_toggle_i);
  assign j_o = jk[1];
  assign k_o = jk[0];

endmodule

// File: rtl/jk_bank_driver.sv
// Command-driven J/K/ClrN/PreN generator: accepts a command, drives one
// excitation cycle, checks the bank against the expected value and retries.
module jk_bank_driver
  import jk_bank_driver_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [WIDTH-1:0] CmdTgt,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             ClrN,
  output logic             PreN,
  output logic             Done,
  output logic             Err
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic       USE_TGL     = (USE_TOGGLE != 0);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [2:0]       retry_q, retry_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] exJ, exK;

  // Excitation always targets the expected value from the live bank Q,
  // so a retry automatically recomputes only the bits still wrong.
  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    jk_excite_bit u_bit (
      .q_i         (Q[i]),
      .t_i         (exp_q[i]),
      .use_toggle_i(USE_TGL),
      .j_o         (exJ[i]),
      .k_o         (exK[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      exp_q   <= '0;
      retry_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    exp_d   = exp_q;
    retry_d = retry_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          op_d    = op_e'(CmdOp);
          retry_d = 3'd0;
          err_d   = 1'b0;
          state_d = ST_DRIVE;
          unique case (op_e'(CmdOp))
            OP_LOAD:   exp_d = CmdTgt;
            OP_CLEAR:  exp_d = '0;
            OP_PRESET: exp_d = '1;
            OP_TOGGLE: exp_d = ~Q;
            default:   exp_d = CmdTgt;
          endcase
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (Q == exp_q) begin
          err_d   = 1'b0;
          state_d = ST_FIN;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 3'd1;
          state_d = ST_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear and preset only occur in their own DRIVE cycles with J=K=0,
  // so the strobes can never overlap or combine with a toggle.
  always_comb begin
    CmdReady = 1'b0;
    J        = '0;
    K        = '0;
    ClrN     = 1'b1;
    PreN     = 1'b1;
    Done     = 1'b0;
    Err      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        CmdReady = !Rst;
      end
      ST_DRIVE: begin
        unique case (op_q)
          OP_LOAD: begin
            J = exJ;
            K = exK;
          end
          OP_CLEAR:  ClrN = 1'b0;
          OP_PRESET: PreN = 1'b0;
          OP_TOGGLE: begin
            if (retry_q == 3'd0) begin
              J = '1;
              K = '1;
            end else begin
              J = exJ;
              K = exK;
            end
          end
          default: begin
            J = '0;
            K = '0;
          end
        endcase
      end
      ST_CHECK: begin
        CmdReady = 1'b0;
      end
      ST_FIN: begin
        Done = 1'b1;
        Err  = err_q;
      end
      default: begin
        CmdReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver: two instances (set/reset and toggle
// encodings), each closing the loop through a behavioural JK flop bank.
module tb_jk_bank_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmdValid [2];
  logic [1:0] cmdOp    [2];
  logic [3:0] cmdTgt   [2];
  logic       cmdReady [2];
  logic [3:0] q        [2];
  logic [3:0] j        [2];
  logic [3:0] k        [2];
  logic       clrN     [2];
  logic       preN     [2];
  logic       done     [2];
  logic       err      [2];

  logic [3:0] stuckMask;
  logic       preloadEn [2];
  logic [3:0] preloadVal;

  typedef struct packed {
    logic       err;
    logic [3:0] q;
  } expT;
  expT sb[$];

  int testsRun  = 0;
  int failCount = 0;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2), .USE_TOGGLE(0)) dutA (
    .CLK(clk), .Rst(rst), .CmdValid(cmdValid[0]), .CmdReady(cmdReady[0]),
    .CmdOp(cmdOp[0]), .CmdTgt(cmdTgt[0]), .Q(q[0]), .J(j[0]), .K(k[0]),
    .ClrN(clrN[0]), .PreN(preN[0]), .Done(done[0]), .Err(err[0])
  );

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2), .USE_TOGGLE(1)) dutB (
    .CLK(clk), .Rst(rst), .CmdValid(cmdValid[1]), .CmdReady(cmdReady[1]),
    .CmdOp(cmdOp[1]), .CmdTgt(cmdTgt[1]), .Q(q[1]), .J(j[1]), .K(k[1]),
    .ClrN(clrN[1]), .PreN(preN[1]), .Done(done[1]), .Err(err[1])
  );

  // Reference JK flop bank with clear priority over preset.
  function automatic logic [3:0] bankNext(input logic [3:0] qc, input logic [3:0] jc,
                                          input logic [3:0] kc, input logic cn,
                                          input logic pn);
    logic [3:0] n;
    if (!cn) begin
      n = 4'b0000;
    end else if (!pn) begin
      n = 4'b1111;
    end else begin
      for (int b = 0; b < 4; b++) begin
        case ({jc[b], kc[b]})
          2'b00:   n[b] = qc[b];
          2'b01:   n[b] = 1'b0;
          2'b10:   n[b] = 1'b1;
          default: n[b] = ~qc[b];
        endcase
      end
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        q[i] <= 4'b0000;
      end else if (preloadEn[i]) begin
        q[i] <= preloadVal;
      end else begin
        q[i] <= bankNext(q[i], j[i], k[i], clrN[i], preN[i]) & ~stuckMask;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic preload(input int idx, input logic [3:0] val);
    preloadVal     = val;
    preloadEn[idx] = 1'b1;
    @(negedge clk);
    preloadEn[idx] = 1'b0;
  endtask

  // Leaves the caller in the DRIVE cycle (n+1) of the accepted command.
  task automatic applyStimulus(input int idx, input logic [1:0] op,
                               input logic [3:0] tgt, input bit holdValid);
    int w = 0;
    while (!cmdReady[idx] && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready_before_cmd", 32'(cmdReady[idx]), 32'd1);
    cmdValid[idx] = 1'b1;
    cmdOp[idx]    = op;
    cmdTgt[idx]   = tgt;
    @(negedge clk);
    if (!holdValid) cmdValid[idx] = 1'b0;
  endtask

  task automatic popAndCheck(input string tag, input int idx);
    expT e;
    checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_err"}, 32'(err[idx]), 32'(e.err));
      checkOutput({tag, "_q"}, 32'(q[idx]), 32'(e.q));
    end
  endtask

  task automatic waitDone(input int idx, input string tag, input int expLat,
                          input int startCycle);
    int c = startCycle;
    while (!done[idx] && c < 40) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_done"}, 32'(done[idx]), 32'd1);
    checkOutput({tag, "_latency"}, 32'(c), 32'(expLat));
    if (done[idx]) popAndCheck(tag, idx);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int clrCnt, preCnt, clrAt, preAt, doneCnt, overlap, driveCnt, doneAt, doneSeen;

    rst        = 1'b1;
    stuckMask  = 4'b0000;
    preloadVal = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      cmdValid[i]  = 1'b0;
      cmdOp[i]     = 2'b00;
      cmdTgt[i]    = 4'b0000;
      preloadEn[i] = 1'b0;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready_a", 32'(cmdReady[0]), 32'd0);
    checkOutput("rst_ready_b", 32'(cmdReady[1]), 32'd0);
    checkOutput("rst_j", 32'(j[0]), 32'd0);
    checkOutput("rst_k", 32'(k[0]), 32'd0);
    checkOutput("rst_strobes", 32'({clrN[0], preN[0]}), 32'd3);
    checkOutput("rst_done_err", 32'({done[0], err[0]}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready_a", 32'(cmdReady[0]), 32'd1);
    checkOutput("post_rst_ready_b", 32'(cmdReady[1]), 32'd1);

    // LOAD 1010 from 0110, set/reset encoding
    preload(0, 4'b0110);
    sb.push_back('{err: 1'b0, q: 4'b1010});
    applyStimulus(0, 2'b00, 4'b1010, 1'b0);
    checkOutput("load_j", 32'(j[0]), 32'b1000);
    checkOutput("load_k", 32'(k[0]), 32'b0100);
    checkOutput("load_ready_drive", 32'(cmdReady[0]), 32'd0);
    @(negedge clk);
    checkOutput("load_q_check", 32'(q[0]), 32'b1010);
    waitDone(0, "load", 3, 2);
    @(negedge clk);
    checkOutput("load_ready_n4", 32'(cmdReady[0]), 32'd1);

    // Same LOAD, toggle encoding
    preload(1, 4'b0110);
    sb.push_back('{err: 1'b0, q: 4'b1010});
    applyStimulus(1, 2'b00, 4'b1010, 1'b0);
    checkOutput("loadt_j", 32'(j[1]), 32'b1100);
    checkOutput("loadt_k", 32'(k[1]), 32'b1100);
    waitDone(1, "loadt", 3, 1);

    // CLEAR then PRESET with CmdValid held high
    @(negedge clk);
    preload(0, 4'b0101);
    sb.push_back('{err: 1'b0, q: 4'b0000});
    sb.push_back('{err: 1'b0, q: 4'b1111});
    applyStimulus(0, 2'b01, 4'b0000, 1'b1);
    cmdOp[0] = 2'b10;
    clrCnt = 0; preCnt = 0; clrAt = 0; preAt = 0; doneCnt = 0; overlap = 0;
    for (c = 1; c <= 10; c++) begin
      if (!clrN[0]) begin clrCnt++; clrAt = c; end
      if (!preN[0]) begin preCnt++; preAt = c; cmdValid[0] = 1'b0; end
      if (!clrN[0] && !preN[0]) overlap++;
      if ((!clrN[0] || !preN[0]) && (j[0] & k[0]) != 4'b0000) overlap++;
      if (done[0]) begin
        doneCnt++;
        popAndCheck(doneCnt == 1 ? "clear" : "preset", 0);
      end
      @(negedge clk);
    end
    cmdValid[0] = 1'b0;
    checkOutput("clr_count", 32'(clrCnt), 32'd1);
    checkOutput("clr_cycle", 32'(clrAt), 32'd1);
    checkOutput("pre_count", 32'(preCnt), 32'd1);
    checkOutput("pre_cycle", 32'(preAt), 32'd5);
    checkOutput("clrpre_done_count", 32'(doneCnt), 32'd2);
    checkOutput("strobe_overlap", 32'(overlap), 32'd0);

    // Stuck Q[0]=0, LOAD 0001: two retries then Err
    stuckMask = 4'b0001;
    preload(0, 4'b0000);
    sb.push_back('{err: 1'b1, q: 4'b0000});
    applyStimulus(0, 2'b00, 4'b0001, 1'b0);
    driveCnt = 0; doneAt = 0;
    for (c = 1; c <= 12; c++) begin
      if (j[0][0] && !k[0][0]) driveCnt++;
      if (done[0] && doneAt == 0) begin
        doneAt = c;
        popAndCheck("stuck", 0);
      end
      @(negedge clk);
    end
    checkOutput("stuck_drives", 32'(driveCnt), 32'd3);
    checkOutput("stuck_done_cycle", 32'(doneAt), 32'd7);
    stuckMask = 4'b0000;

    // TOGGLE all from 0011
    preload(0, 4'b0011);
    sb.push_back('{err: 1'b0, q: 4'b1100});
    applyStimulus(0, 2'b11, 4'b0000, 1'b0);
    checkOutput("toggle_j", 32'(j[0]), 32'b1111);
    checkOutput("toggle_k", 32'(k[0]), 32'b1111);
    waitDone(0, "toggle", 3, 1);

    // Reset held for 2 cycles starting mid-DRIVE drops the command
    @(negedge clk);
    preload(0, 4'b0000);
    applyStimulus(0, 2'b00, 4'b1111, 1'b0);
    checkOutput("rstdrv_j_before", 32'(j[0]), 32'b1111);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstdrv_jk", 32'({j[0], k[0]}), 32'd0);
    checkOutput("rstdrv_strobes", 32'({clrN[0], preN[0]}), 32'd3);
    checkOutput("rstdrv_done", 32'(done[0]), 32'd0);
    checkOutput("rstdrv_ready_in_rst", 32'(cmdReady[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstdrv_ready_after", 32'(cmdReady[0]), 32'd1);
    doneSeen = 0;
    for (c = 0; c < 6; c++) begin
      if (done[0]) doneSeen++;
      @(negedge clk);
    end
    checkOutput("rstdrv_no_done", 32'(doneSeen), 32'd0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
